// File: rtl/pipe_skid_stage_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage.
package pipe_skid_stage_pkg;

  typedef logic [1:0] pipe_occ_t;

  // Encoded as {skidV, mainV}. 2'b10 (skid held without main) is never legal.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } pipe_state_e;

  localparam int          PERF_CNT_W = 32;
  localparam logic [63:0] PC_RESET   = 64'h8000_0000;

  function automatic pipe_state_e stateOf(input logic mainV, input logic skidV);
    return pipe_state_e'({skidV, mainV});
  endfunction

endpackage

// File: rtl/pipe_skid_stage_perf_ctr.sv
// Free-running event counter: +1 per enabled cycle, wraps at all-ones, cleared by synchronous reset.
// Registered output, one cycle after the counted event; no handshake.
module pipe_perf_ctr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage: registered ready, 1-cycle latency, full throughput; in_ready never depends on out_ready.
// Optional perf counters behind PIPE_SKID_PERF_EN; without it stall_cycles/bubble_cycles read 0.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int           W          = 64,
  parameter logic [W-1:0] BUBBLE_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  bubble,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output pipe_occ_t             occupancy,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] bubble_cycles
);

  logic         mainV;
  logic         skidV;
  logic [W-1:0] mainD;
  logic [W-1:0] skidD;
  logic         acc;
  logic         dq;
  pipe_state_e  curState;

  assign curState  = stateOf(mainV, skidV);
  assign in_ready  = !skidV && !bubble && !reset;
  assign acc       = in_valid && in_ready;
  assign dq        = mainV && out_ready;
  assign out_valid = mainV;
  assign out_data  = mainD;
  assign occupancy = pipe_occ_t'({1'b0, mainV} + {1'b0, skidV});

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mainV <= 1'b0;
      skidV <= 1'b0;
      mainD <= BUBBLE_VAL;
      skidD <= BUBBLE_VAL;
    end else begin
      case (curState)
        EMPTY: begin
          if (acc) begin
            mainV <= 1'b1;
            mainD <= in_data;
          end
        end
        FULL: begin
          if (acc && dq) begin
            mainD <= in_data;
          end else if (dq) begin
            mainV <= 1'b0;
            mainD <= BUBBLE_VAL;
          end else if (acc) begin
            skidV <= 1'b1;
            skidD <= in_data;
          end
        end
        default: begin
          // SKID: in_ready is low, so only a drain can move anything.
          if (dq) begin
            mainD <= skidD;
            skidV <= 1'b0;
            skidD <= BUBBLE_VAL;
          end
        end
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (reset) curState != pipe_state_e'(2'b10))
    else $error("pipe_skid_stage: skid entry held without main entry");

`ifdef PIPE_SKID_PERF_EN
  pipe_perf_ctr #(.WIDTH(PERF_CNT_W)) uStallCtr (
    .clk   (clk),
    .reset (reset),
    .en    (mainV && !out_ready && !flush),
    .count (stall_cycles)
  );

  pipe_perf_ctr #(.WIDTH(PERF_CNT_W)) uBubbleCtr (
    .clk   (clk),
    .reset (reset),
    .en    (bubble && in_valid),
    .count (bubble_cycles)
  );
`else
  assign stall_cycles  = '0;
  assign bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus random traffic against a queue-based reference model.
module tb_pipe_skid_stage;
  import pipe_skid_stage_pkg::*;

  localparam int           W      = 16;
  localparam logic [W-1:0] BUBBLE = 16'h0BAD;
`ifdef PIPE_SKID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                  clk;
  logic                  reset;
  logic                  flush;
  logic                  bubble;
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_data;
  pipe_occ_t             occupancy;
  logic [PERF_CNT_W-1:0] stall_cycles;
  logic [PERF_CNT_W-1:0] bubble_cycles;

  pipe_skid_stage #(.W(W), .BUBBLE_VAL(BUBBLE)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .bubble        (bubble),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .occupancy     (occupancy),
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: the held entries in order, plus event counts.
  logic [W-1:0] heldQ[$];
  logic [31:0]  mStall;
  logic [31:0]  mBubble;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutputs(input logic expRdy);
    logic [W-1:0] expData;
    expData = BUBBLE;
    if (heldQ.size() > 0) expData = heldQ[0];
    chk("in_ready", 64'(in_ready), 64'(expRdy));
    chk("out_valid", 64'(out_valid), 64'(heldQ.size() > 0));
    chk("out_data", 64'(out_data), 64'(expData));
    chk("occupancy", 64'(occupancy), 64'(heldQ.size()));
    chk("stall_cycles", 64'(stall_cycles), PERF ? 64'(mStall) : 64'd0);
    chk("bubble_cycles", 64'(bubble_cycles), PERF ? 64'(mBubble) : 64'd0);
  endtask

  // One clock: drive at negedge, check pre-edge outputs, advance the model, return at posedge+1.
  task automatic cycle(input logic r, input logic f, input logic b, input logic iv,
                       input logic [W-1:0] d, input logic ordy);
    logic expRdy;
    logic acc;
    logic dq;
    @(negedge clk);
    reset     = r;
    flush     = f;
    bubble    = b;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    expRdy = !r && !b && (heldQ.size() < 2);
    checkOutputs(expRdy);
    acc = iv && expRdy;
    dq  = (heldQ.size() > 0) && ordy;
    if (r) begin
      heldQ.delete();
      mStall  = '0;
      mBubble = '0;
    end else begin
      if (heldQ.size() > 0 && !ordy && !f) mStall++;
      if (b && iv) mBubble++;
      if (f) begin
        heldQ.delete();
      end else begin
        if (dq) void'(heldQ.pop_front());
        if (acc) heldQ.push_back(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, ordy);
  endtask

  task automatic send(input logic [W-1:0] d, input logic ordy);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, d, ordy);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; bubble = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mStall = '0; mBubble = '0;
    repeat (2) @(posedge clk);

    // Reset and fill
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    send(16'h00A1, 1'b1);
    chk("fill_a1_valid", 64'(out_valid), 64'd1);
    chk("fill_a1_data", 64'(out_data), 64'h00A1);
    send(16'h00A2, 1'b1);
    chk("fill_a2_data", 64'(out_data), 64'h00A2);
    send(16'h00A3, 1'b1);
    chk("fill_a3_data", 64'(out_data), 64'h00A3);
    idle(1'b1);

    // Backpressure into skid
    send(16'h00B1, 1'b0);
    chk("bp_occ1", 64'(occupancy), 64'd1);
    send(16'h00B2, 1'b0);
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    send(16'h00B3, 1'b0);
    chk("bp_b3_held", 64'(occupancy), 64'd2);
    send(16'h00B3, 1'b1);
    chk("bp_b2_out", 64'(out_data), 64'h00B2);
    send(16'h00B3, 1'b1);
    chk("bp_b3_out", 64'(out_data), 64'h00B3);
    idle(1'b1);

    // Flush while in SKID
    send(16'h00C1, 1'b0);
    send(16'h00C2, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h00C3, 1'b0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_data", 64'(out_data), 64'(BUBBLE));
    idle(1'b1);

    // Bubble while FULL and draining
    send(16'h00D1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h00D2, 1'b1);
    chk("bubble_gap_valid", 64'(out_valid), 64'd0);
    send(16'h00D2, 1'b1);
    chk("bubble_d2_data", 64'(out_data), 64'h00D2);
    idle(1'b1);

    // Reset mid-operation in SKID
    send(16'h00E1, 1'b0);
    send(16'h00E2, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h00E3, 1'b0);
    chk("rst_mid_occ", 64'(occupancy), 64'd0);
    chk("rst_mid_stall", 64'(stall_cycles), 64'd0);
    chk("rst_mid_bubble", 64'(bubble_cycles), 64'd0);

    // Perf counters: 3 bubble cycles from empty, then 5 stall cycles
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b1);
    send(16'h0022, 1'b0);
    repeat (5) idle(1'b0);
    chk("perf_stall", 64'(stall_cycles), PERF ? 64'd5 : 64'd0);
    chk("perf_bubble", 64'(bubble_cycles), PERF ? 64'd3 : 64'd0);
    idle(1'b1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) < 1),
            1'($urandom_range(0, 99) < 5),
            1'($urandom_range(0, 99) < 20),
            1'($urandom_range(0, 99) < 70),
            W'($urandom),
            1'($urandom_range(0, 99) < 60));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
